mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  Memory-stage consumer of the EX/MEM pipeline register outputs. Drives a
//  16-bit data memory over a req/ack handshake for loads and stores.
//  Generates the pipeline write-enable that feeds the .write inputs of the
//  pipeline registers, and holds it low while an access is outstanding.
//  Presents write-back data, rd and regwrite toward the MEM/WB register.
// PARAMETERS
//  TIMEOUT_CYCLES  64  max cycles in BUSY waiting for mem_ack before fault
//  CNT_W           16  width of saturating stall-cycle counter
// PORTS
//  clock         in   1   single clock, all state on posedge
//  rst           in   1   asynchronous, active-high reset
//  mem2reg       in   1   EX/MEM: instruction is a load
//  memwrite      in   1   EX/MEM: instruction is a store
//  regwrite_in   in   1   EX/MEM: instruction writes a register
//  mem_aluout    in   16  EX/MEM: address / ALU result
//  mem_b         in   16  EX/MEM: store data
//  rd_in         in   4   EX/MEM: destination register
//  pipe_write    out  1   1 = pipeline registers may capture, 0 = hold
//  dmem_req      out  1   memory request, registered
//  dmem_we       out  1   1 = store, 0 = load, registered
//  dmem_addr     out  16  registered address
//  dmem_wdata    out  16  registered store data
//  dmem_rdata    in   16  load data, valid with dmem_ack
//  dmem_ack      in   1   one-cycle completion pulse
//  wb_data       out  16  load data (DONE) or mem_aluout
//  wb_rd         out  4   = rd_in
//  wb_regwrite   out  1   = regwrite_in & ~mem_fault
//  mem_fault     out  1   sticky: timeout or load+store conflict
//  stall_cycles  out  CNT_W  count of cycles with pipe_write = 0, saturating
// BEHAVIOUR
//  - Reset (async): state = IDLE. dmem_req/we/addr/wdata = 0. rdata_q = 0.
//    timeout counter = 0. mem_fault = 0. stall_cycles = 0.
//    pipe_write = 1 (IDLE, no access).
//  - FSM has four states: IDLE, BUSY, DONE, FAULT.
//  - IDLE, no access (mem2reg = memwrite = 0): pipe_write = 1. wb_data = mem_aluout.
//  - IDLE, access: pipe_write = 0 combinationally. Latch addr = mem_aluout,
//    wdata = mem_b, we = memwrite. Set dmem_req = 1. Go to BUSY next edge.
//  - BUSY: pipe_write = 0. dmem_req held 1 with stable addr/we/wdata.
//    Timeout counter increments each cycle.
//    - dmem_ack = 1: capture dmem_rdata into rdata_q, drop dmem_req, go to DONE.
//    - Counter reaches TIMEOUT_CYCLES - 1 without ack: drop dmem_req, set
//      mem_fault, go to FAULT.
//  - DONE: pipe_write = 1 for exactly one cycle. wb_data = rdata_q for a load,
//    mem_aluout for a store. Always returns to IDLE; the next instruction is
//    then in EX/MEM. Minimum load/store latency is 3 cycles with an ack on the
//    first BUSY cycle (2 stall cycles).
//  - FAULT: pipe_write = 0, dmem_req = 0, wb_regwrite = 0. Leaves only on rst.
//  - Conflict: mem2reg & memwrite in IDLE -> no request, set mem_fault,
//    go to FAULT.
//  - Ignored inputs: dmem_ack outside BUSY (spurious, no state change);
//    rdata outside an ack.
//  - stall_cycles: +1 every cycle pipe_write = 0. Saturates at all-ones, no wrap.
//  - Reset asserted mid-BUSY aborts the access: dmem_req = 0 immediately.
// STRUCTURE
//  - Shared include mem_defs.vh holds the state encodings
//    (IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2, FAULT = 2'd3) and the 16-bit
//    data width constant.
//  - One sub-module: sat_counter (CNT_W, inc, rst, out) for stall_cycles.
//  - FSM, timeout counter and request registers stay in this module.
// TESTING
//  1. ALU op, mem2reg = memwrite = 0, aluout = 16'h1234 -> pipe_write = 1
//     every cycle, wb_data = 16'h1234, dmem_req never asserted.
//  2. Load addr 16'h0040, ack 2 cycles after req with rdata = 16'hBEEF
//     -> pipe_write low 3 cycles, then wb_data = 16'hBEEF in DONE,
//     stall_cycles = 3.
//  3. Store addr 16'h0010, data 16'hA5A5, ack first BUSY cycle
//     -> dmem_we = 1, wdata = 16'hA5A5, pipe_write low 2 cycles.
//  4. No ack for 64 cycles -> mem_fault = 1, FSM in FAULT, dmem_req = 0,
//     pipe_write stays 0 until rst.
//  5. mem2reg = memwrite = 1 -> no request, mem_fault = 1 next edge.
//     Spurious ack in IDLE -> no effect.
//  6. rst pulse mid-BUSY -> dmem_req = 0 asynchronously, state IDLE,
//     stall_cycles = 0. Back-to-back loads afterwards each complete.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the memory-stage access unit.
// State encodings are fixed so debug tooling can decode o_state directly.
package mem_access_unit_pkg;

    localparam int DATA_W = 16;
    localparam int RD_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } state_t;

endpackage

// File: rtl/mem_access_unit_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clock,
    input  logic             i_rst,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_out
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clock or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_out = r_count;

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: issues req/ack data-memory accesses for loads/stores and
// stalls the pipeline (o_pipe_write = 0) while an access is outstanding.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic              i_clock,
    input  logic              i_rst,
    input  logic              i_mem2reg,
    input  logic              i_memwrite,
    input  logic              i_regwrite_in,
    input  logic [DATA_W-1:0] i_mem_aluout,
    input  logic [DATA_W-1:0] i_mem_b,
    input  logic [RD_W-1:0]   i_rd_in,
    output logic              o_pipe_write,
    output logic              o_dmem_req,
    output logic              o_dmem_we,
    output logic [DATA_W-1:0] o_dmem_addr,
    output logic [DATA_W-1:0] o_dmem_wdata,
    input  logic [DATA_W-1:0] i_dmem_rdata,
    input  logic              i_dmem_ack,
    output logic [DATA_W-1:0] o_wb_data,
    output logic [RD_W-1:0]   o_wb_rd,
    output logic              o_wb_regwrite,
    output logic              o_mem_fault,
    output logic [CNT_W-1:0]  o_stall_cycles,
    output state_t            o_state
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_dmem_req;
    logic              r_dmem_we;
    logic [DATA_W-1:0] r_dmem_addr;
    logic [DATA_W-1:0] r_dmem_wdata;
    logic [DATA_W-1:0] r_rdata_q;
    logic              r_mem_fault;
    logic              w_access;
    logic              w_conflict;
    logic              w_timeout;
    logic              w_pipe_write;
    logic [DATA_W-1:0] w_wb_data;

    assign w_access   = i_mem2reg | i_memwrite;
    assign w_conflict = i_mem2reg & i_memwrite;
    assign w_timeout  = (r_to_cnt == TO_LAST);

    always_ff @(posedge i_clock or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pipe_write = 1'b0;
        w_wb_data    = i_mem_aluout;
        case (r_state)
            IDLE: begin
                w_pipe_write = ~w_access;
                if (w_conflict) begin
                    w_next_state = FAULT;
                end else if (w_access) begin
                    w_next_state = BUSY;
                end
            end
            BUSY: begin
                if (i_dmem_ack) begin
                    w_next_state = DONE;
                end else if (w_timeout) begin
                    w_next_state = FAULT;
                end
            end
            DONE: begin
                // Single release cycle; the next instruction arrives in IDLE.
                w_pipe_write = 1'b1;
                w_next_state = IDLE;
                if (!r_dmem_we) begin
                    w_wb_data = r_rdata_q;
                end
            end
            FAULT: begin
                w_next_state = FAULT;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_rst) begin
        if (i_rst) begin
            r_to_cnt     <= '0;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_rdata_q    <= '0;
            r_mem_fault  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_conflict) begin
                        r_mem_fault <= 1'b1;
                    end else if (w_access) begin
                        r_dmem_addr  <= i_mem_aluout;
                        r_dmem_wdata <= i_mem_b;
                        r_dmem_we    <= i_memwrite;
                        r_dmem_req   <= 1'b1;
                        r_to_cnt     <= '0;
                    end
                end
                BUSY: begin
                    if (i_dmem_ack) begin
                        r_rdata_q  <= i_dmem_rdata;
                        r_dmem_req <= 1'b0;
                    end else if (w_timeout) begin
                        r_dmem_req  <= 1'b0;
                        r_mem_fault <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .i_clock (i_clock),
        .i_rst   (i_rst),
        .i_inc   (~w_pipe_write),
        .o_out   (o_stall_cycles)
    );

    assign o_pipe_write  = w_pipe_write;
    assign o_dmem_req    = r_dmem_req;
    assign o_dmem_we     = r_dmem_we;
    assign o_dmem_addr   = r_dmem_addr;
    assign o_dmem_wdata  = r_dmem_wdata;
    assign o_wb_data     = w_wb_data;
    assign o_wb_rd       = i_rd_in;
    assign o_wb_regwrite = i_regwrite_in & ~r_mem_fault;
    assign o_mem_fault   = r_mem_fault;
    assign o_state       = r_state;

endmodule
